// File: rtl/lcd_bus_decoder.sv
// 8080-style LCD write-bus receiver: command/parameter decode and RGB565 pixel capture.
// Optional frame counter: define LCD_BUS_DECODER_FRAMECNT_EN.
module lcd_bus_decoder #(
  parameter int H_RES   = 320,
  parameter int V_RES   = 240,
  parameter int COORD_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr,
  input  logic               dcx,
  input  logic [7:0]         d,
  output logic               cmd_valid,
  output logic [7:0]         cmd_code,
  output logic               pix_valid,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic [15:0]        pix_rgb,
  output logic               frame_done,
  output logic               disp_on,
  output logic [7:0]         frame_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CASET,
    S_PASET,
    S_RAMWR,
    S_SKIP
  } state_t;

  localparam logic [COORD_W-1:0] XE_RST = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] YE_RST = COORD_W'(V_RES - 1);

  state_t state, state_n;

  logic               wr_q;
  logic               ev;
  logic [1:0]         byte_idx;
  logic [7:0]         p_hi;
  logic [COORD_W-1:0] p_start;
  logic [7:0]         rgb_hi;
  logic [COORD_W-1:0] xs, xe, ys, ye;
  logic [COORD_W-1:0] cx, cy;

  assign ev = wr & ~wr_q;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  // next-state decode on each accepted byte
  always_comb begin
    state_n = state;
    if (ev) begin
      if (!dcx) begin
        unique case (1'b1)
          (d == 8'h2A): state_n = S_CASET;
          (d == 8'h2B): state_n = S_PASET;
          (d == 8'h2C): state_n = S_RAMWR;
          (d == 8'h29),
          (d == 8'h28),
          (d == 8'h01): state_n = S_IDLE;
          default:      state_n = S_SKIP;
        endcase
      end else if ((state == S_CASET || state == S_PASET) &&
                   byte_idx == 2'd3) begin
        state_n = S_IDLE;
      end
    end
  end

  // datapath: window, cursor, pixel assembly and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q       <= 1'b0;
      byte_idx   <= 2'd0;
      p_hi       <= 8'h00;
      p_start    <= '0;
      rgb_hi     <= 8'h00;
      xs         <= '0;
      xe         <= XE_RST;
      ys         <= '0;
      ye         <= YE_RST;
      cx         <= '0;
      cy         <= '0;
      cmd_valid  <= 1'b0;
      cmd_code   <= 8'h00;
      pix_valid  <= 1'b0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_rgb    <= 16'h0000;
      frame_done <= 1'b0;
      disp_on    <= 1'b0;
    end else begin
      wr_q       <= wr;
      cmd_valid  <= 1'b0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (ev && !dcx) begin
        cmd_valid <= 1'b1;
        cmd_code  <= d;
        byte_idx  <= 2'd0;
        unique case (1'b1)
          (d == 8'h2C): begin
            cx <= xs;
            cy <= ys;
          end
          (d == 8'h29): disp_on <= 1'b1;
          (d == 8'h28): disp_on <= 1'b0;
          (d == 8'h01): begin
            xs      <= '0;
            xe      <= XE_RST;
            ys      <= '0;
            ye      <= YE_RST;
            cx      <= '0;
            cy      <= '0;
            disp_on <= 1'b0;
          end
          default: ;
        endcase
      end else if (ev) begin
        unique case (state)
          S_CASET, S_PASET: begin
            byte_idx <= byte_idx + 2'd1;
            unique case (byte_idx)
              2'd0: p_hi <= d;
              2'd1: p_start <= COORD_W'({p_hi, d});
              2'd2: p_hi <= d;
              2'd3: begin
                if (state == S_CASET) begin
                  xs <= p_start;
                  xe <= COORD_W'({p_hi, d});
                end else begin
                  ys <= p_start;
                  ye <= COORD_W'({p_hi, d});
                end
              end
              default: ;
            endcase
          end
          S_RAMWR: begin
            if (!byte_idx[0]) begin
              rgb_hi   <= d;
              byte_idx <= 2'd1;
            end else begin
              byte_idx   <= 2'd0;
              pix_valid  <= 1'b1;
              pix_x      <= cx;
              pix_y      <= cy;
              pix_rgb    <= {rgb_hi, d};
              frame_done <= (cx == xe) && (cy == ye);
              if (cx == xe) begin
                cx <= xs;
                cy <= (cy == ye) ? ys : cy + 1'b1;
              end else begin
                cx <= cx + 1'b1;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef LCD_BUS_DECODER_FRAMECNT_EN
  // completed-frame counter, wraps at 255
  always_ff @(posedge clk) begin
    if (rst)
      frame_cnt <= 8'h00;
    else if (ev && !dcx && d == 8'h01)
      frame_cnt <= 8'h00;
    else if (frame_done)
      frame_cnt <= frame_cnt + 8'h01;
  end
`else
  assign frame_cnt = 8'h00;
`endif

endmodule
